// File: rtl/cpu64_l1_pkg.sv
// Shared types and constants for the cpu64 L1 memory-side port.
package cpu64_l1_pkg;

    localparam int DATA_W   = 64;
    localparam int BE_W     = 8;
    localparam int ADDR_W   = 64;
    localparam int WORD_OFF = 3;

    // One request as presented on the req/gnt port.
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Replace the bytes of old_w selected by be with the matching bytes of new_w.
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cpu64_l1_rsp_pipe.sv
// Fixed-latency read response pipe: valid + data shift register.
// Data is zeroed on bubbles so the last stage reads 0 whenever it is not valid.
module cpu64_l1_rsp_pipe
    import cpu64_l1_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1][DATA_W-1:0] dat_pipe;

    // Shift valid and data one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= push;
            dat_pipe[1] <= push ? push_data : '0;
            for (int i = 2; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign vld_o  = vld_pipe[STAGES];
    assign data_o = dat_pipe[STAGES];

endmodule

// File: rtl/cpu64_l1_mem_responder.sv
// Memory-side responder for the cpu64 L1 req/gnt/rvalid port.
// Serves byte-masked writes and fixed-latency in-order reads from a word array,
// with optional grant throttling and a cap on outstanding reads.
module cpu64_l1_mem_responder
    import cpu64_l1_pkg::*;
#(
    parameter int MEM_WORDS       = 1024,
    parameter int GNT_DELAY       = 0,
    parameter int RD_LATENCY      = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int HOLD_W = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(GNT_DELAY);
    localparam logic [OUT_W:0]    OUT_MAX  = (OUT_W+1)'(MAX_OUTSTANDING);

    mem_req_t          req;
    logic [IDX_W-1:0]  idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [OUT_W-1:0]  outstanding;
    logic              rd_room;
    logic              rd_gnt;
    logic              wr_gnt;
    logic [DATA_W-1:0] rd_word;
    logic              unused_addr_bits;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    assign req = '{we: we_i, be: be_i, addr: addr_i, wdata: wdata_i};

    // Offset bits and bits above the index alias onto the same word.
    assign idx              = req.addr[WORD_OFF +: IDX_W];
    assign unused_addr_bits = ^{req.addr[WORD_OFF-1:0], req.addr[ADDR_W-1:WORD_OFF+IDX_W]};

    // A read returning this cycle frees its slot in time for a new read grant.
    assign rd_room = (({1'b0, outstanding} - {{OUT_W{1'b0}}, rvalid_o}) < OUT_MAX);

    // Writes are never throttled by the outstanding-read cap.
    assign gnt_o  = rst_n && req.addr[0] == req.addr[0] && req_i && (hold_cnt == HOLD_MAX) && (req.we || rd_room);
    assign rd_gnt = gnt_o && !req.we;
    assign wr_gnt = gnt_o &&  req.we;

    // Count cycles a request has waited; restart on grant or when req drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (!req_i || gnt_o) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Track reads granted but not yet returned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({rd_gnt, rvalid_o})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Byte-masked array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_gnt) begin
            mem[idx] <= merge_bytes(mem[idx], req.wdata, req.be);
        end
    end

    // Only one grant per cycle, so the read sample never races a write to the same word.
    assign rd_word = mem[idx];

    cpu64_l1_rsp_pipe #(
        .STAGES (RD_LATENCY)
    ) u_rsp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_gnt),
        .push_data (rd_word),
        .vld_o     (rvalid_o),
        .data_o    (rdata_o)
    );

endmodule

// File: tb/tb_cpu64_l1_mem_responder.sv
// Directed bench for cpu64_l1_mem_responder: three instances cover the default
// configuration, a grant delay of 3, and RD_LATENCY=4 with MAX_OUTSTANDING=2.
module tb_cpu64_l1_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req    [3];
    logic        we     [3];
    logic [7:0]  be     [3];
    logic [63:0] addr   [3];
    logic [63:0] wdata  [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [63:0] rdata  [3];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu64_l1_mem_responder u_a (
        .clk(clk), .rst_n(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0])
    );

    cpu64_l1_mem_responder #(.GNT_DELAY(3)) u_b (
        .clk(clk), .rst_n(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1])
    );

    cpu64_l1_mem_responder #(.RD_LATENCY(4), .MAX_OUTSTANDING(2)) u_c (
        .clk(clk), .rst_n(rst_n), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]),
        .addr_i(addr[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
        .rdata_o(rdata[2])
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; be[d] = 8'h00; addr[d] = '0; wdata[d] = '0;
        end
    endtask

    // Issue one write on instance d and hold it until granted (bounded).
    task automatic do_write(input int d, input logic [63:0] a, input logic [7:0] b,
                            input logic [63:0] w);
        int n = 0;
        req[d] = 1'b1; we[d] = 1'b1; be[d] = b; addr[d] = a; wdata[d] = w;
        @(negedge clk);
        while (!gnt[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (gnt[d] !== 1'b1) begin
            miscompares++;
            $display("FAIL write_gnt dut%0d addr=%h: got gnt=%b required 1", d, a, gnt[d]);
        end
        @(posedge clk); #1;
        req[d] = 1'b0; we[d] = 1'b0;
    endtask

    // Issue one read; report cycles waited for grant and cycles from grant to rvalid.
    task automatic do_read(input int d, input logic [63:0] a, output logic [63:0] data,
                           output int gl, output int lat);
        req[d] = 1'b1; we[d] = 1'b0; addr[d] = a;
        gl = 0; lat = 0; data = '0;
        @(negedge clk);
        while (!gnt[d] && gl < 20) begin
            @(negedge clk);
            gl++;
        end
        if (!gnt[d]) begin
            gl = -1; lat = -1;
            @(posedge clk); #1;
            req[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rvalid[d] && lat < 30);
        if (!rvalid[d]) lat = -1;
        else            data = rdata[d];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) req[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vectors += 3;
            if (gnt[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_gnt dut%0d: got %b required 0", d, gnt[d]);
            end
            if (rvalid[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_rvalid dut%0d: got %b required 0", d, rvalid[d]);
            end
            if (rdata[d] !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_rdata dut%0d: got %h required 0", d, rdata[d]);
            end
        end
        @(posedge clk); #1;
        idle_all();
        rst_n = 1'b1;
    endtask

    task automatic test_byte_write();
        logic [63:0] data;
        int gl, lat;
        do_write(0, 64'h1000, 8'hFF, 64'h0);
        do_write(0, 64'h1000, 8'h01, 64'hAA);
        do_read(0, 64'h1000, data, gl, lat);
        vectors += 3;
        if (gl !== 0) begin
            miscompares++;
            $display("FAIL rd_gnt_wait: got %0d cycles required 0", gl);
        end
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL rd_latency: got %0d required 2", lat);
        end
        if (data !== 64'h00000000000000AA) begin
            miscompares++;
            $display("FAIL byte_write: got %h required 00000000000000aa", data);
        end
    endtask

    task automatic test_partial_be();
        logic [63:0] data;
        int gl, lat;
        do_write(0, 64'h2008, 8'hFF, 64'h1122334455667788);
        do_write(0, 64'h2008, 8'hF0, 64'hBEEFBEEF00000000);
        do_read(0, 64'h2008, data, gl, lat);
        vectors++;
        if (data !== 64'hBEEFBEEF55667788) begin
            miscompares++;
            $display("FAIL partial_be: got %h required beefbeef55667788", data);
        end
        do_write(0, 64'h2008, 8'h00, 64'hFFFFFFFFFFFFFFFF);
        do_read(0, 64'h2008, data, gl, lat);
        vectors++;
        if (data !== 64'hBEEFBEEF55667788) begin
            miscompares++;
            $display("FAIL be_zero_noop: got %h required beefbeef55667788", data);
        end
    endtask

    task automatic test_alias();
        logic [63:0] data;
        int gl, lat;
        do_write(0, 64'h0, 8'hFF, 64'h5A5A);
        do_read(0, 64'h2000, data, gl, lat);
        vectors++;
        if (data !== 64'h5A5A) begin
            miscompares++;
            $display("FAIL alias_wrap: got %h required 5a5a", data);
        end
        do_read(0, 64'h7, data, gl, lat);
        vectors++;
        if (data !== 64'h5A5A) begin
            miscompares++;
            $display("FAIL offset_ignored: got %h required 5a5a", data);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_d [3];
        logic        exp_g, exp_r;
        exp_d[0] = 64'h1111; exp_d[1] = 64'h2222; exp_d[2] = 64'h3333;
        for (int i = 0; i < 3; i++) do_write(0, 64'h10 + 64'(8*i), 8'hFF, exp_d[i]);
        for (int k = 0; k < 7; k++) begin
            req[0] = (k < 3); we[0] = 1'b0;
            addr[0] = 64'h10 + 64'(8*((k < 3) ? k : 0));
            exp_g = (k < 3);
            exp_r = (k >= 2 && k <= 4);
            @(negedge clk);
            vectors += 3;
            if (gnt[0] !== exp_g) begin
                miscompares++;
                $display("FAIL b2b_gnt cyc%0d: got %b required %b", k, gnt[0], exp_g);
            end
            if (rvalid[0] !== exp_r) begin
                miscompares++;
                $display("FAIL b2b_rvalid cyc%0d: got %b required %b", k, rvalid[0], exp_r);
            end
            if (rdata[0] !== (exp_r ? exp_d[exp_r ? k-2 : 0] : 64'h0)) begin
                miscompares++;
                $display("FAIL b2b_rdata cyc%0d: got %h required %h", k, rdata[0],
                         exp_r ? exp_d[exp_r ? k-2 : 0] : 64'h0);
            end
            @(posedge clk); #1;
        end
        req[0] = 1'b0;
    endtask

    task automatic test_gnt_delay();
        logic [6:0] req_seq;
        logic [6:0] gnt_seq;
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 8'hFF; addr[1] = 64'h40; wdata[1] = 64'h1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (gnt[1] !== (k == 3)) begin
                miscompares++;
                $display("FAIL gnt_delay_held cyc%0d: got %b required %b", k, gnt[1], (k == 3));
            end
            @(posedge clk); #1;
        end
        req_seq = 7'b1111011;
        gnt_seq = 7'b1000000;
        for (int k = 0; k < 7; k++) begin
            req[1] = req_seq[k];
            @(negedge clk);
            vectors++;
            if (gnt[1] !== gnt_seq[k]) begin
                miscompares++;
                $display("FAIL gnt_delay_restart cyc%0d: got %b required %b", k, gnt[1], gnt_seq[k]);
            end
            @(posedge clk); #1;
        end
        req[1] = 1'b0; we[1] = 1'b0;
    endtask

    task automatic test_outstanding();
        logic [10:0] exp_g;
        logic [10:0] exp_r;
        logic [63:0] exp_d [3];
        int idx = 0;
        int nrv = 0;
        exp_g = 11'b00000010011;
        exp_r = 11'b00100110000;
        exp_d[0] = 64'h11; exp_d[1] = 64'h22; exp_d[2] = 64'h33;
        for (int i = 0; i < 3; i++) do_write(2, 64'h100 + 64'(8*i), 8'hFF, exp_d[i]);
        for (int k = 0; k < 11; k++) begin
            req[2] = (idx < 3); we[2] = 1'b0;
            addr[2] = 64'h100 + 64'(8*idx);
            @(negedge clk);
            vectors += 2;
            if (gnt[2] !== exp_g[k]) begin
                miscompares++;
                $display("FAIL max_out_gnt cyc%0d: got %b required %b", k, gnt[2], exp_g[k]);
            end
            if (rvalid[2] !== exp_r[k]) begin
                miscompares++;
                $display("FAIL max_out_rvalid cyc%0d: got %b required %b", k, rvalid[2], exp_r[k]);
            end
            if (rvalid[2] && nrv < 3) begin
                vectors++;
                if (rdata[2] !== exp_d[nrv]) begin
                    miscompares++;
                    $display("FAIL max_out_order rsp%0d: got %h required %h", nrv, rdata[2], exp_d[nrv]);
                end
                nrv++;
            end
            if (gnt[2]) idx++;
            @(posedge clk); #1;
        end
        req[2] = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [63:0] data;
        int gl, lat;
        for (int k = 0; k < 2; k++) begin
            req[2] = 1'b1; we[2] = 1'b0; addr[2] = 64'h100 + 64'(8*k);
            @(negedge clk);
            vectors++;
            if (gnt[2] !== 1'b1) begin
                miscompares++;
                $display("FAIL midflight_gnt rd%0d: got %b required 1", k, gnt[2]);
            end
            @(posedge clk); #1;
        end
        req[2] = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (rvalid[2] !== 1'b0) begin
                miscompares++;
                $display("FAIL midflight_dropped cyc%0d: got rvalid=%b required 0", k, rvalid[2]);
            end
            @(posedge clk); #1;
        end
        do_read(2, 64'h108, data, gl, lat);
        vectors += 2;
        if (data !== 64'h22) begin
            miscompares++;
            $display("FAIL midflight_retained: got %h required 22", data);
        end
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL midflight_latency: got %0d required 4", lat);
        end
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_partial_be();
        test_alias();
        test_back_to_back();
        test_gnt_delay();
        test_outstanding();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
